timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
Front-end control stage that sits directly upstream of the BCD digit timer (timer10) chain. It synchronises and debounces four raw push-buttons and runs a run/pause/stop/setup state machine. It drives the digit counters' start, pause, stop and set_time level inputs, plus a prescaled count-enable tick for the counter clock domain gating.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a debounced level changes (>=2)
TICK_DIV, 10, Clk cycles per tick pulse while running (>=2)

Ports:
Clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; forces reset values immediately
btn_start  input  1  raw start button, asynchronous to Clk
btn_pause  input  1  raw pause/resume button
btn_stop  input  1  raw stop button
btn_set  input  1  raw set-time button
start  output  1  level to timer start input
pause  output  1  level to timer pause input
stop  output  1  level to timer stop input
set_time  output  1  level to timer set_time input
tick  output  1  one-cycle count enable
state_o  output  3  current state code

Behaviour:
- Reset: state IDLE; start=pause=stop=set_time=tick=0; state_o=0; all sync flops, debounced levels, edge-history flops, debounce counters and prescaler cleared.
- Per button: 2-flop synchroniser -> debouncer -> rising-edge detect.
- Debouncer: counter clears when sync output equals the debounced level. Otherwise it increments. When the counter is DEBOUNCE_CYCLES-1 and the sample still differs, the debounced level takes the sample and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES samples never changes the level.
- Event = debounced level & ~previous debounced level. It is high for exactly one cycle and only on press (rising edge); releases generate nothing.
- Latency: raw high first sampled at edge 1 -> state change at edge DEBOUNCE_CYCLES+3 (edge 7 at default).
- A button held through reset deassertion is treated as a fresh press.
- State codes: IDLE=0, RUN=1, PAUSED=2, STOPPED=3, SETUP=4. Codes 5-7 -> IDLE on the next edge.
- Event priority when several events occur in the same cycle: set > stop > pause > start. Only the highest-priority event that is legal in the current state is acted on; the others are dropped.
- Transitions:
  - IDLE: set->SETUP; start->RUN.
  - RUN: set->SETUP; stop->STOPPED; pause->PAUSED; start ignored.
  - PAUSED: set->SETUP; stop->STOPPED; pause or start->RUN.
  - STOPPED: set->SETUP; all others ignored (STOPPED is left only via set or reset).
  - SETUP: set->IDLE; start->RUN; stop and pause ignored.
- Outputs are a Moore decode of the state register and carry no combinational path from the button pins:
  - start=1 in RUN and PAUSED.
  - pause=1 in PAUSED.
  - stop=1 in STOPPED.
  - set_time=1 in SETUP.
  - state_o = state code.
- Prescaler (width clog2(TICK_DIV)):
  - In RUN it counts 0..TICK_DIV-1 and wraps to 0.
  - In any other state it is held at 0, so pause restarts the tick phase on resume.
  - tick = (state==RUN) && (prescaler==TICK_DIV-1).
  - First tick occurs in the TICK_DIV-th cycle after RUN entry; afterwards tick has an exact period of TICK_DIV.
  - Leaving RUN on the same edge that the prescaler would wrap suppresses that tick.
- Reset asserted mid-operation: all outputs drop to 0 immediately (asynchronous), the prescaler clears and any pending debounce is discarded.

Test Plan:
1. Reset release, btn_start held high 10 cycles (DEBOUNCE_CYCLES=4) -> state_o 0->1 at edge 7; start=1; first tick 10 cycles later, then one tick every 10 cycles.
2. btn_pause 2-cycle glitch while RUN -> no state change; clean btn_pause press -> PAUSED, pause=1, start=1, tick=0. Second press -> RUN, prescaler restarts from 0.
3. RUN, btn_stop pressed -> STOPPED, stop=1, start=0. btn_start and btn_pause presses -> still STOPPED. btn_set press -> SETUP, set_time=1, stop=0.
4. Debounced events from btn_set and btn_stop arriving in the same cycle from RUN -> SETUP, not STOPPED. btn_start and btn_pause arriving together in RUN -> PAUSED.
5. SETUP, btn_start press -> RUN with set_time=0 and start=1 on the same edge. SETUP, btn_set press -> IDLE, all level outputs 0.
6. reset pulsed asynchronously mid-cycle while PAUSED -> outputs 0 before the next Clk edge, state_o=0. btn_start held across reset release -> RUN at edge DEBOUNCE_CYCLES+3 after release.

Source files
------------

// File: rtl/timer_ctrl.sv
// Button front-end and run/pause/stop/setup control for the BCD digit timer.
// Produces Moore level controls and a prescaled count-enable tick.

module timer_ctrl_debounce #(
    parameter int N = 4
) (
    input  logic Clk,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CMAX = CW'(N - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Level flips only after N consecutive samples that disagree with it.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CMAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = level_q & ~prev_q;

endmodule

module timer_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 10
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_stop,
    input  logic       btn_set,
    output logic       start,
    output logic       pause,
    output logic       stop,
    output logic       set_time,
    output logic       tick,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSED  = 3'd2,
        STOPPED = 3'd3,
        SETUP   = 3'd4
    } state_e;

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    state_e        state_q;
    state_e        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          ev_start;
    logic          ev_pause;
    logic          ev_stop;
    logic          ev_set;

    timer_ctrl_debounce #(.N(DEBOUNCE_CYCLES)) u_db_start (
        .Clk     (Clk),
        .reset   (reset),
        .btn_i   (btn_start),
        .press_o (ev_start)
    );

    timer_ctrl_debounce #(.N(DEBOUNCE_CYCLES)) u_db_pause (
        .Clk     (Clk),
        .reset   (reset),
        .btn_i   (btn_pause),
        .press_o (ev_pause)
    );

    timer_ctrl_debounce #(.N(DEBOUNCE_CYCLES)) u_db_stop (
        .Clk     (Clk),
        .reset   (reset),
        .btn_i   (btn_stop),
        .press_o (ev_stop)
    );

    timer_ctrl_debounce #(.N(DEBOUNCE_CYCLES)) u_db_set (
        .Clk     (Clk),
        .reset   (reset),
        .btn_i   (btn_set),
        .press_o (ev_set)
    );

    // Checks run set > stop > pause > start; illegal events fall through.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ev_set) begin
                    state_d = SETUP;
                end else if (ev_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ev_set) begin
                    state_d = SETUP;
                end else if (ev_stop) begin
                    state_d = STOPPED;
                end else if (ev_pause) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (ev_set) begin
                    state_d = SETUP;
                end else if (ev_stop) begin
                    state_d = STOPPED;
                end else if (ev_pause || ev_start) begin
                    state_d = RUN;
                end
            end
            STOPPED: begin
                if (ev_set) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (ev_set) begin
                    state_d = IDLE;
                end else if (ev_start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Phase restarts whenever RUN is entered, so resume begins a full period.
    always_comb begin
        presc_d = '0;
        if (state_q == RUN && state_d == RUN && presc_q != PMAX) begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end

    assign start    = (state_q == RUN) || (state_q == PAUSED);
    assign pause    = (state_q == PAUSED);
    assign stop     = (state_q == STOPPED);
    assign set_time = (state_q == SETUP);
    assign tick     = (state_q == RUN) && (presc_q == PMAX);
    assign state_o  = state_q;

endmodule
